// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO that drains into the MiniUART by polling its LSR and
//             writing its data register one byte at a time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef OFF_UART_DATA
`define OFF_UART_DATA 3'd0
`endif
`ifndef OFF_UART_LSR
`define OFF_UART_LSR 3'd5
`endif

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GUARD_CYC  = 4
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovf,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  u_stb,
    output logic                  u_we,
    output logic [2:0]            u_add,
    output logic [31:0]           u_dat_o,
    input  logic [31:0]           u_dat_i
);

    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = 1;
    localparam int                  c_GW        = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [c_GW-1:0]     c_GUARD_LD  = c_GW'(GUARD_CYC - 1);
    localparam logic [c_GW-1:0]     c_GUARD_ONE = 1;
    localparam int                  c_LSR_TX_RDY = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_WRITE = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [c_GW-1:0]       r_guard;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_unused_dat;

    assign w_full       = (r_count == c_DEPTH_CNT);
    assign w_push       = wr_en & ~w_full;
    assign w_pop        = (r_state == S_WRITE);
    assign w_unused_dat = ^{u_dat_i[31:c_LSR_TX_RDY+1], u_dat_i[c_LSR_TX_RDY-1:0]};

    assign full     = w_full;
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign overflow = r_overflow;

    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A dropped push outranks a simultaneous clear.
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_guard <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (u_dat_i[c_LSR_TX_RDY]) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_guard <= c_GUARD_LD;
                    r_state <= S_GUARD;
                end
                S_GUARD: begin
                    // Lets the UART drop its ready bit before the LSR is read again.
                    if (r_guard == '0) begin
                        r_state <= (r_count != '0) ? S_POLL : S_IDLE;
                    end else begin
                        r_guard <= r_guard - c_GUARD_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        u_stb   = 1'b0;
        u_we    = 1'b0;
        u_add   = `OFF_UART_LSR;
        u_dat_o = 32'd0;
        case (r_state)
            S_POLL: begin
                u_stb = 1'b1;
            end
            S_WRITE: begin
                u_stb   = 1'b1;
                u_we    = 1'b1;
                u_add   = `OFF_UART_DATA;
                u_dat_o = {24'd0, r_mem[r_rd_ptr]};
            end
            default: begin
                u_stb = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the MiniUART. The CPU pushes bytes into a byte FIFO. The block then acts as a bus master on the MiniUART slave port: it polls the line status register and writes the next byte to the data register each time the transmitter reports ready. This lets software queue a burst of characters without busy-waiting on the 9600–115200 baud line.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16 by default).
- GUARD_CYC, 4: idle cycles inserted after every data write, before the LSR is polled again.

Ports:
- CLK_I  in  1  clock; the same clock as the MiniUART.
- RST_I  in  1  reset, synchronous, active-high.
- wr_en  in  1  push strobe from the CPU side.
- wr_data  in  8  byte to push.
- clr_ovf  in  1  clears the overflow flag.
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky; set when a push is attempted while full.
- u_stb  out  1  to MiniUART STB_I.
- u_we  out  1  to MiniUART WE_I.
- u_add  out  3  to MiniUART ADD_I[4:2].
- u_dat_o  out  32  to MiniUART DAT_I.
- u_dat_i  in  32  from MiniUART DAT_O.

## Operation
FIFO:
- Circular buffer with rd_ptr and wr_ptr, each DEPTH_LOG2 bits wide, wrapping modulo 2^DEPTH_LOG2.
- count is held as a separate register.
- Push: wr_en=1 and full=0 stores wr_data at wr_ptr, then wr_ptr+1.
- Push while full: the byte is dropped and overflow is set to 1.
- overflow clears only on clr_ovf or reset. If set and clear land in the same cycle, set wins.
- Pop occurs only in state WRITE: rd_ptr+1.
- Push and pop in the same cycle: count is unchanged.
- A push into a full FIFO is still dropped even if a pop happens in that cycle, because full is evaluated on the pre-edge count.

FSM states (Moore outputs, decoded from the state register):
- IDLE
  - Outputs: u_stb=0, u_we=0, u_add=OFF_UART_LSR, u_dat_o=0.
  - Transition: go to POLL when count≠0.
- POLL
  - Outputs: u_stb=1, u_we=0, u_add=OFF_UART_LSR.
  - Transition: if u_dat_i[5]=1 (transmitter ready), go to WRITE; otherwise stay in POLL.
- WRITE
  - Outputs: u_stb=1, u_we=1, u_add=OFF_UART_DATA, u_dat_o={24'b0, fifo[rd_ptr]}.
  - Action: pop.
  - Transition: go to GUARD and load the guard counter with GUARD_CYC-1.
- GUARD
  - Outputs: u_stb=0, u_we=0.
  - Action: decrement the guard counter.
  - Transition: at 0, go to POLL if the post-pop count≠0, else to IDLE.
- The guard period covers the MiniUART's load toggle and the delay before its ts bit drops. Without it, a stale ready indication could cause a second write.
- OFF_UART_DATA and OFF_UART_LSR are the shared UART header macros.
- WRITE lasts exactly one cycle, so the MiniUART sees exactly one write strobe per byte.

## Timing
- Reset values (synchronous): state=IDLE, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0, u_stb=0, u_we=0, u_add=OFF_UART_LSR, u_dat_o=0.
- Output derivation: full, empty and count come combinationally from the count register.
- Push visibility: a push at edge N shows in count after edge N.
- Push into an empty FIFO while IDLE:
  - POLL is asserted in cycle N+1.
  - If the LSR reads ready, WRITE occurs in cycle N+2.
  - The byte is on u_dat_o in that cycle.
- Back-to-back bytes with the transmitter always ready: WRITE cycles are spaced GUARD_CYC+2 cycles apart (WRITE, GUARD×GUARD_CYC, POLL).
- Ready not yet reported: POLL holds indefinitely. No timeout.
- FIFO order: bytes leave in push order, and pointer wrap-around is seamless.
- Reset asserted mid-WRITE: the byte is discarded along with the whole FIFO. u_stb/u_we are 0 in the cycle after the reset edge.

## Test plan
- Reset, then push 0x41 with LSR bit5=1 → exactly one cycle with u_stb=1, u_we=1, u_add=OFF_UART_DATA, u_dat_o=0x00000041, two cycles after the push edge. Afterwards count=0, empty=1, FSM returns to IDLE.
- Hold LSR bit5=0, push 3 bytes → FSM stays in POLL, no write strobes, count=3. Raise bit5 → the bytes are written in order, with write strobes GUARD_CYC+2 cycles apart.
- Push 17 bytes into the default 16-deep FIFO with the UART stalled → full=1, count=16, overflow=1, the 17th byte is lost. Pulse clr_ovf → overflow=0.
- Push on the same cycle as a WRITE pop with count=5 → count remains 5, and data order is preserved across pointer wrap after more than 16 total pushes.
- Assert RST_I during the WRITE cycle with 4 bytes queued → next cycle: count=0, u_stb=0, state IDLE, no further writes.
- GUARD_CYC=1 build: 2 bytes queued, ready held high → write strobes exactly 3 cycles apart.
